// File: rtl/lut_pkg.sv
// Shared defaults and FSM encoding for the programmable branch-target table.
package lut_pkg;
  localparam int LUT_LABEL_W    = 8;
  localparam int LUT_PC_W       = 12;
  localparam int LUT_DEPTH      = 64;
  localparam int LUT_DEFAULT_PC = 0;

  typedef enum logic [1:0] {
    S_LABEL,
    S_PCHI,
    S_PCLO,
    S_COMMIT
  } rx_state_t;
endpackage

// File: rtl/lut_loader_if.sv
// Byte-wide valid/ready load stream carrying (label, pc_hi, pc_lo) records.
interface lut_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lut_frame_rx.sv
// Receives 3-byte records and emits a one-cycle commit strobe with label and pc.
module lut_frame_rx
  import lut_pkg::*;
#(
  parameter int LABEL_W = LUT_LABEL_W,
  parameter int PC_W    = LUT_PC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  lut_loader_if.slave        bus,
  output logic               o_commit,
  output logic [LABEL_W-1:0] o_label,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_busy
);
  rx_state_t          r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_commit;
  logic [LABEL_W-1:0] r_label;
  logic [PC_W-1:0]    r_pc;
  logic               w_xfer;

  assign w_xfer      = bus.in_valid && r_ready;
  assign bus.in_ready = r_ready;
  assign o_commit    = r_commit;
  assign o_label     = r_label;
  assign o_pc        = r_pc;
  assign o_busy      = r_busy;

  // ready/busy are registered alongside the state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_LABEL;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
      r_label  <= '0;
      r_pc     <= '0;
    end else begin
      r_commit <= 1'b0;
      if (clear) begin
        r_state <= S_LABEL;
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_LABEL: if (w_xfer) begin
            r_label <= LABEL_W'(bus.in_data);
            r_busy  <= 1'b1;
            r_state <= S_PCHI;
          end
          S_PCHI: if (w_xfer) begin
            // high byte bits above PC_W-1 are dropped
            r_pc[PC_W-1:8] <= bus.in_data[PC_W-9:0];
            r_state        <= S_PCLO;
          end
          S_PCLO: if (w_xfer) begin
            r_pc[7:0] <= bus.in_data;
            r_ready   <= 1'b0;
            r_commit  <= 1'b1;
            r_state   <= S_COMMIT;
          end
          default: begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_LABEL;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/lut_loader.sv
// Reloadable label -> next_pc table fed by a byte stream, with combinational lookup.
module lut_loader
  import lut_pkg::*;
#(
  parameter int LABEL_W = LUT_LABEL_W,
  parameter int PC_W    = LUT_PC_W,
  parameter int DEPTH   = LUT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  lut_loader_if.slave                in_if,
  input  logic [LABEL_W-1:0]         rd_label,
  output logic [PC_W-1:0]            rd_pc,
  output logic                       rd_hit,
  output logic                       load_busy,
  output logic [$clog2(DEPTH+1)-1:0] entry_count,
  output logic                       err_range
);
  localparam int               IDX_W   = $clog2(DEPTH);
  localparam int               CNT_W   = $clog2(DEPTH+1);
  localparam logic [LABEL_W:0] DEPTH_L = (LABEL_W+1)'(DEPTH);

  logic [DEPTH-1:0]   r_valid;
  logic [PC_W-1:0]    r_pc [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic               w_commit;
  logic [LABEL_W-1:0] w_label;
  logic [PC_W-1:0]    w_pc;
  logic               w_in_range;
  logic               w_we;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [DEPTH-1:0]   w_we_vec;
  logic               w_rd_in_range;
  logic [IDX_W-1:0]   w_rd_idx;

  lut_frame_rx #(.LABEL_W(LABEL_W), .PC_W(PC_W)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (in_if),
    .o_commit (w_commit),
    .o_label  (w_label),
    .o_pc     (w_pc),
    .o_busy   (load_busy)
  );

  assign w_in_range = {1'b0, w_label} < DEPTH_L;
  assign w_wr_idx   = w_label[IDX_W-1:0];
  // clear in the commit cycle wins over the write
  assign w_we       = w_commit && !clear && w_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_we_vec[gi] = w_we && (w_wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_pc[i] <= '0;
    end else if (clear) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we_vec[i]) begin
          r_valid[i] <= 1'b1;
          r_pc[i]    <= w_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_we && !r_valid[w_wr_idx]) r_count <= r_count + CNT_W'(1);
      if (w_commit && !w_in_range)    r_err   <= 1'b1;
    end
  end

  assign w_rd_in_range = {1'b0, rd_label} < DEPTH_L;
  assign w_rd_idx      = rd_label[IDX_W-1:0];
  assign rd_hit        = w_rd_in_range && r_valid[w_rd_idx];
  assign rd_pc         = rd_hit ? r_pc[w_rd_idx] : PC_W'(LUT_DEFAULT_PC);
  assign entry_count   = r_count;
  assign err_range     = r_err;
endmodule

// File: tb/tb_lut_loader.sv
// Directed table-driven bench for lut_loader: loads, overwrite, range errors, clear, async reset.
module tb_lut_loader;
  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] rd_label;
  logic [11:0] rd_pc;
  logic       rd_hit;
  logic       load_busy;
  logic [6:0] entry_count;
  logic       err_range;
  int         checks;
  int         errors;

  lut_loader_if lif ();

  lut_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_if       (lif),
    .rd_label    (rd_label),
    .rd_pc       (rd_pc),
    .rd_hit      (rd_hit),
    .load_busy   (load_busy),
    .entry_count (entry_count),
    .err_range   (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int label;
    int hi;
    int lo;
    int hit_in_commit;
    int exp_pc;
    int exp_hit;
    int exp_count;
    int exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int b);
    int n;
    n = 0;
    lif.in_valid = 1'b1;
    lif.in_data  = 8'(b);
    while (!lif.in_ready && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) chk("in_ready_timeout", 0, 1);
    step();
    lif.in_valid = 1'b0;
  endtask

  task automatic send_record(input int l, input int h, input int lo);
    send_byte(l);
    send_byte(h);
    send_byte(lo);
    $display("record label=%0d hi=0x%02h lo=0x%02h", l, h, lo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    lif.in_valid = 1'b0;
    lif.in_data  = 8'h00;
    rd_label = 8'd2;

    vecs[0] = '{2,  8'h01, 8'h43, 0, 323,  1, 1, 0};
    vecs[1] = '{2,  8'h00, 8'hC9, 1, 201,  1, 1, 0};
    vecs[2] = '{70, 8'h00, 8'h10, 0, 0,    0, 1, 1};
    vecs[3] = '{5,  8'hFF, 8'hFF, 0, 4095, 1, 2, 1};
    vecs[4] = '{63, 8'h00, 8'h07, 0, 7,    1, 3, 1};
    vecs[5] = '{64, 8'h00, 8'h08, 0, 0,    0, 3, 1};

    #12;
    rst_n = 1'b1;
    step();

    chk("reset_in_ready", int'(lif.in_ready), 1);
    chk("reset_load_busy", int'(load_busy), 0);
    chk("reset_count", int'(entry_count), 0);
    chk("reset_err", int'(err_range), 0);
    chk("reset_rd_pc", int'(rd_pc), 0);
    chk("reset_rd_hit", int'(rd_hit), 0);

    for (int i = 0; i < 6; i++) begin
      rd_label = 8'(vecs[i].label);
      send_record(vecs[i].label, vecs[i].hi, vecs[i].lo);
      chk($sformatf("v%0d_commit_ready", i), int'(lif.in_ready), 0);
      chk($sformatf("v%0d_commit_busy", i), int'(load_busy), 1);
      chk($sformatf("v%0d_commit_hit", i), int'(rd_hit), vecs[i].hit_in_commit);
      step();
      chk($sformatf("v%0d_rd_pc", i), int'(rd_pc), vecs[i].exp_pc);
      chk($sformatf("v%0d_rd_hit", i), int'(rd_hit), vecs[i].exp_hit);
      chk($sformatf("v%0d_count", i), int'(entry_count), vecs[i].exp_count);
      chk($sformatf("v%0d_err", i), int'(err_range), vecs[i].exp_err);
      chk($sformatf("v%0d_ready_after", i), int'(lif.in_ready), 1);
    end

    rd_label = 8'd2;
    #1;
    chk("persist_label2", int'(rd_pc), 201);

    // backpressure gap between bytes 1 and 2
    send_byte(43);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("gap_busy_%0d", c), int'(load_busy), 1);
    end
    send_byte(8'h01);
    send_byte(8'hB5);
    $display("record label=43 hi=0x01 lo=0xb5 (with gap)");
    step();
    rd_label = 8'd43;
    #1;
    chk("gap_rd_pc", int'(rd_pc), 437);
    chk("gap_rd_hit", int'(rd_hit), 1);
    chk("gap_count", int'(entry_count), 4);

    // clear after byte1 of a record, with a byte presented during clear
    send_byte(10);
    send_byte(8'h00);
    clear = 1'b1;
    lif.in_valid = 1'b1;
    lif.in_data  = 8'h55;
    step();
    clear = 1'b0;
    lif.in_valid = 1'b0;
    $display("clear pulse mid-record");
    chk("clear_count", int'(entry_count), 0);
    chk("clear_err", int'(err_range), 0);
    chk("clear_busy", int'(load_busy), 0);
    chk("clear_ready", int'(lif.in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      int lbl;
      lbl = (k == 0) ? 2 : (k == 1) ? 5 : (k == 2) ? 43 : 63;
      rd_label = 8'(lbl);
      #1;
      chk($sformatf("clear_hit_%0d", lbl), int'(rd_hit), 0);
      chk($sformatf("clear_pc_%0d", lbl), int'(rd_pc), 0);
    end
    send_record(0, 8'h00, 8'h02);
    step();
    rd_label = 8'd0;
    #1;
    chk("after_clear_pc", int'(rd_pc), 2);
    chk("after_clear_hit", int'(rd_hit), 1);
    chk("after_clear_count", int'(entry_count), 1);

    // clear landing on the commit cycle suppresses the write
    send_record(7, 8'h00, 8'h09);
    clear = 1'b1;
    step();
    clear = 1'b0;
    rd_label = 8'd7;
    #1;
    chk("clear_commit_hit", int'(rd_hit), 0);
    chk("clear_commit_count", int'(entry_count), 0);
    chk("clear_commit_busy", int'(load_busy), 0);

    // async reset mid-record with non-reset state present
    send_record(1, 8'h00, 8'h03);
    send_record(200, 8'h00, 8'h00);
    step();
    chk("pre_rst_count", int'(entry_count), 1);
    chk("pre_rst_err", int'(err_range), 1);
    send_byte(9);
    send_byte(8'h01);
    rd_label = 8'd1;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-record");
    chk("arst_ready", int'(lif.in_ready), 1);
    chk("arst_busy", int'(load_busy), 0);
    chk("arst_count", int'(entry_count), 0);
    chk("arst_err", int'(err_range), 0);
    chk("arst_hit", int'(rd_hit), 0);
    chk("arst_pc", int'(rd_pc), 0);
    #10;
    rst_n = 1'b1;
    step();
    send_record(1, 8'h00, 8'h2A);
    step();
    #1;
    chk("post_rst_pc", int'(rd_pc), 42);
    chk("post_rst_count", int'(entry_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Programmable branch-target table: the writer side of the label-to-next_pc lookup.
- A host or loader streams (label, pc) records byte-by-byte over a valid/ready interface.
- The block assembles the records, commits them into a register-based table, and serves combinational lookups label -> next_pc.
- It replaces the hard-coded table, so jump targets can be reloaded per program without resynthesis.

Parameters:
- LABEL_W, 8, label width; also the width of the lookup input.
- PC_W, 12, next_pc width; must be 9..16.
- DEPTH, 64, number of table entries; labels 0..DEPTH-1 are storable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous single-cycle pulse; invalidates the whole table and aborts any partial record.
- in_valid  input  1  load byte valid.
- in_ready  output  1  block can accept a load byte this cycle.
- in_data  input  8  load byte.
- rd_label  input  LABEL_W  lookup label.
- rd_pc  output  PC_W  lookup result; combinational from rd_label and table state.
- rd_hit  output  1  lookup label has a valid entry.
- load_busy  output  1  a record is partially received or committing.
- entry_count  output  $clog2(DEPTH+1)  number of valid entries.
- err_range  output  1  sticky flag: a record with label >= DEPTH was dropped.

Behaviour:
- Reset (async assert, rst_n low):
  - all valid bits 0, all stored pc 0, FSM in S_LABEL.
  - in_ready=1, load_busy=0, entry_count=0, err_range=0.
- Record framing, 3 bytes:
  - byte0 = label.
  - byte1 = pc[15:8]; bits above PC_W-1 are ignored.
  - byte2 = pc[7:0].
- A byte transfers only when in_valid && in_ready on a rising edge.
- FSM states:
  - S_LABEL: on transfer, latch label -> S_PCHI.
  - S_PCHI: on transfer, latch pc high byte -> S_PCLO.
  - S_PCLO: on transfer, latch pc low byte -> S_COMMIT.
  - S_COMMIT: in_ready=0 for exactly one cycle; performs the write -> S_LABEL.
- in_ready=1 in S_LABEL, S_PCHI and S_PCLO.
- load_busy=1 in every state except S_LABEL.
- Throughput: one record per 4 cycles at best.
- Commit when label < DEPTH:
  - pc[label] <= assembled pc; valid[label] <= 1.
  - entry_count increments only if the entry was previously invalid. Overwriting a valid label updates pc and leaves the count unchanged.
- Commit when label >= DEPTH: no table write, count unchanged, err_range <= 1 (sticky).
- Lookup timing:
  - A committed entry is visible on rd_pc/rd_hit in the cycle after S_COMMIT; there is no bypass during S_COMMIT itself.
  - rd_label < DEPTH and valid: rd_pc = stored pc, rd_hit=1.
  - rd_label invalid or >= DEPTH: rd_pc = 0, rd_hit=0. This matches the legacy default target of 0.
- clear (highest priority, synchronous):
  - all valid bits 0, entry_count 0, err_range 0, FSM -> S_LABEL.
  - Stored pc values need not be zeroed; they are masked by valid.
  - A byte presented in the clear cycle is discarded, even if in_ready=1.
  - clear in the S_COMMIT cycle suppresses the write.
- in_valid deasserted mid-record: the FSM holds its state indefinitely; there is no timeout.
- entry_count saturates naturally at DEPTH; it cannot exceed DEPTH.
- rst_n asserted mid-record: the partial record is lost, and the table returns to its reset state.

Decomposition:
- Shared package lut_pkg:
  - default LABEL_W, PC_W, DEPTH localparams.
  - FSM enum {S_LABEL, S_PCHI, S_PCLO, S_COMMIT}.
  - LUT_DEFAULT_PC = 0.
- One sub-module, lut_frame_rx: contains the FSM plus byte assembly, and emits a one-cycle commit strobe with the label and pc.
- The top level holds the valid/pc arrays, the counter, the error flag and the read mux.

Test Plan:
- Reset then idle:
  - in_ready=1, entry_count=0.
  - rd_label=2 -> rd_pc=0, rd_hit=0.
- Load record {2, 0x01, 0x43}:
  - in_ready=0 for one cycle after the third byte.
  - Next cycle rd_label=2 -> rd_pc=323, rd_hit=1, entry_count=1.
- Overwrite and out-of-range:
  - Load {2, 0x00, 0xC9} -> rd_pc=201, entry_count stays 1.
  - Load {70, 0x00, 0x10} -> err_range=1, entry_count 1.
  - rd_label=70 -> 0, rd_hit 0.
- Backpressure gaps: drop in_valid for 5 cycles between bytes 1 and 2 of {43, 0x01, 0xB5} -> load_busy held 1, final rd_pc=437 at label 43.
- Clear and abort:
  - Pulse clear after byte1 of a record -> entry_count=0, all rd_hit=0, FSM back to S_LABEL.
  - A following full record {0, 0x00, 0x02} is received correctly -> rd_pc=2.
- Async reset mid-record: drop rst_n between bytes of a partial record -> all outputs at reset values immediately, without waiting for a clock edge.
